// File: rtl/top_vec_mul.sv
// -----------------------------------------------------------------------------
// top_vec_mul : 16-lane int8 vector x matrix multiply engine
//
// Purpose
//   The host writes int8 row vectors into the input SRAM and pushes full 16x16
//   int8 weight matrices into a weight FIFO. It then pops a matrix and latches
//   it into the weight register, raises start, and streams row addresses with
//   valid_address. Each accepted row x yields y = x * W: sixteen 24-bit
//   wrapped sums, written to the result SRAM at the same address exactly three
//   edges after the request edge. end_ pulses once when the run has drained.
//
// Configuration
//   VEC_MUL_RELU_EN : when defined, negative result lanes are clamped to 0
//                     before the result write. When undefined, raw wrapped
//                     sums are stored.
//
// Ports
//   clk                  in   single clock, rising edge
//   rstn                 in   synchronous, active-HIGH reset
//   start                in   arms a run (level; must drop before the next run)
//   end_                 out  one-cycle done pulse
//   sram_write_enable    in   input SRAM write strobe (blocked by valid_address)
//   sram_address         in   input SRAM write/read/request address
//   sram_data_in         in   input row to write
//   sram_data_out        out  asynchronous read of input SRAM[sram_address]
//   fifo_write_enable    in   push fifo_data_in (dropped when full)
//   fifo_read_enable     in   pop into fifo_data_out (ignored when empty)
//   fifo_data_in         in   weight matrix to push
//   fifo_data_out        out  registered FIFO head (last popped entry)
//   weight_reload        in   latch fifo_data_out into the weight register
//   valid_address        in   sram_address is a compute request this cycle
//   sram_result_address  in   result SRAM read address
//   sram_result_data_out out  asynchronous read of result SRAM
// -----------------------------------------------------------------------------
module top_vec_mul #(
  parameter int ADDRESSSIZE     = 10,
  parameter int WORDSIZE        = 128,
  parameter int WEIGHT_BW       = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int NUM_PE_ROWS     = 16,
  parameter int MATRIX_SIZE     = 16,
  parameter int PARTIAL_SUM_BW  = 24,
  parameter int WORDSIZE_Result = 384,
  parameter int DATA_BW         = 8
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         start,
  output logic                                         end_,
  input  logic                                         sram_write_enable,
  input  logic [ADDRESSSIZE-1:0]                       sram_address,
  input  logic [WORDSIZE-1:0]                          sram_data_in,
  output logic [WORDSIZE-1:0]                          sram_data_out,
  input  logic                                         fifo_write_enable,
  input  logic                                         fifo_read_enable,
  input  logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data_in,
  output logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data_out,
  input  logic                                         weight_reload,
  input  logic                                         valid_address,
  input  logic [ADDRESSSIZE-1:0]                       sram_result_address,
  output logic [WORDSIZE_Result-1:0]                   sram_result_data_out
);

  localparam int FIFO_W  = WEIGHT_BW * NUM_PE_ROWS * MATRIX_SIZE;
  localparam int PROD_BW = DATA_BW + WEIGHT_BW;
  localparam int PTR_BW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BW  = $clog2(FIFO_DEPTH + 1);
  localparam int MEM_DEPTH = 2 ** ADDRESSSIZE;

  localparam logic [PTR_BW-1:0] LAST_PTR = PTR_BW'(FIFO_DEPTH - 1);
  localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(FIFO_DEPTH);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // ---------------------------------------------------------------------------
  // Input SRAM
  // ---------------------------------------------------------------------------
  logic [WORDSIZE-1:0] r_in_mem [MEM_DEPTH];

  // NOTE: storage arrays carry no reset; clearing them would need a port per
  // word and the contents are defined only once the host has written them.
  always_ff @(posedge clk) begin
    if (sram_write_enable && !valid_address)
      r_in_mem[sram_address] <= sram_data_in;
  end

  assign sram_data_out = r_in_mem[sram_address];

  // ---------------------------------------------------------------------------
  // Weight FIFO
  // ---------------------------------------------------------------------------
  logic [FIFO_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_BW-1:0] r_wptr;
  logic [PTR_BW-1:0] r_rptr;
  logic [CNT_BW-1:0] r_count;
  logic [FIFO_W-1:0] r_fifo_head;
  logic              w_push;
  logic              w_pop;

  assign w_push = fifo_write_enable && (r_count != FULL_CNT);
  assign w_pop  = fifo_read_enable  && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push)
      r_fifo_mem[r_wptr] <= fifo_data_in;
  end

  // NOTE: sequential state is always assigned with <=, so every register in
  // this file sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_fifo_head <= '0;
    end else begin
      if (w_push)
        r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr      <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
        r_fifo_head <= r_fifo_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_data_out = r_fifo_head;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic [2:0] r_state;
  logic       r_seen_req;   // at least one request accepted in this run
  logic       r_s1_valid;
  logic       r_s2_valid;
  logic       r_s3_valid;
  logic       w_accept;

  assign w_accept = valid_address && (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state    <= S_IDLE;
      r_seen_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_seen_req <= 1'b0;
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept)        r_seen_req <= 1'b1;
          else if (r_seen_req) r_state    <= S_DRAIN;
        end
        S_DRAIN: begin
          // Empty only once the final result write has happened.
          if (!(r_s1_valid || r_s2_valid || r_s3_valid)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_HOLD;
        S_HOLD: begin
          // Wait for start to drop so a held start cannot retrigger.
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign end_ = (r_state == S_DONE);

  // ---------------------------------------------------------------------------
  // Weight register: only reloaded while no run is in flight.
  // ---------------------------------------------------------------------------
  logic [FIFO_W-1:0] r_weight;

  always_ff @(posedge clk) begin
    if (rstn)
      r_weight <= '0;
    else if (weight_reload && (r_state == S_IDLE || r_state == S_HOLD))
      r_weight <= r_fifo_head;
  end

  // ---------------------------------------------------------------------------
  // Datapath: row fetch -> products -> lane sums -> result write
  // ---------------------------------------------------------------------------
  logic [ADDRESSSIZE-1:0]     r_s1_addr;
  logic [ADDRESSSIZE-1:0]     r_s2_addr;
  logic [ADDRESSSIZE-1:0]     r_s3_addr;
  logic [WORDSIZE-1:0]        r_s1_row;
  logic signed [PROD_BW-1:0]  r_prod [NUM_PE_ROWS][MATRIX_SIZE];
  logic [WORDSIZE_Result-1:0] w_y;
  logic [WORDSIZE_Result-1:0] r_s3_y;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Payload registers follow their valid bit and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_addr <= sram_address;
      r_s1_row  <= r_in_mem[sram_address];
    end
    r_s2_addr <= r_s1_addr;
    r_s3_addr <= r_s2_addr;
    for (int k = 0; k < NUM_PE_ROWS; k++) begin
      for (int c = 0; c < MATRIX_SIZE; c++) begin
        r_prod[k][c] <=
          PROD_BW'($signed(r_s1_row[k*DATA_BW +: DATA_BW])) *
          PROD_BW'($signed(r_weight[(k*MATRIX_SIZE + c)*WEIGHT_BW +: WEIGHT_BW]));
      end
    end
    r_s3_y <= w_y;
  end

  // Lane sums: each product is sign-extended to the lane width and the sum
  // wraps naturally at PARTIAL_SUM_BW bits.
  always_comb begin : lane_sums
    logic [PARTIAL_SUM_BW-1:0] v_acc;
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    w_y   = '0;
    v_acc = '0;
    for (int c = 0; c < MATRIX_SIZE; c++) begin
      v_acc = '0;
      for (int k = 0; k < NUM_PE_ROWS; k++)
        v_acc = v_acc + PARTIAL_SUM_BW'(r_prod[k][c]);
`ifdef VEC_MUL_RELU_EN
      if (v_acc[PARTIAL_SUM_BW-1]) v_acc = '0;
`endif
      w_y[c*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] = v_acc;
    end
  end

  // ---------------------------------------------------------------------------
  // Result SRAM
  // ---------------------------------------------------------------------------
  logic [WORDSIZE_Result-1:0] r_res_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (r_s3_valid)
      r_res_mem[r_s3_addr] <= r_s3_y;
  end

  assign sram_result_data_out = r_res_mem[sram_result_address];

endmodule

// File: tb/tb_top_vec_mul.sv
// -----------------------------------------------------------------------------
// tb_top_vec_mul : self-checking bench for top_vec_mul.
// Expected results come from ref_y(), which evaluates y[c] = sum_k x[k]*W[k][c]
// with integer arithmetic and keeps the low 24 bits of each lane.
// -----------------------------------------------------------------------------
module tb_top_vec_mul;

  localparam int AW = 10;
  localparam int XW = 128;
  localparam int FW = 2048;
  localparam int RW = 384;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          end_;
  logic          sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [XW-1:0] sram_data_in;
  logic [XW-1:0] sram_data_out;
  logic          fifo_write_enable;
  logic          fifo_read_enable;
  logic [FW-1:0] fifo_data_in;
  logic [FW-1:0] fifo_data_out;
  logic          weight_reload;
  logic          valid_address;
  logic [AW-1:0] sram_result_address;
  logic [RW-1:0] sram_result_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  top_vec_mul dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .end_                (end_),
    .sram_write_enable   (sram_write_enable),
    .sram_address        (sram_address),
    .sram_data_in        (sram_data_in),
    .sram_data_out       (sram_data_out),
    .fifo_write_enable   (fifo_write_enable),
    .fifo_read_enable    (fifo_read_enable),
    .fifo_data_in        (fifo_data_in),
    .fifo_data_out       (fifo_data_out),
    .weight_reload       (weight_reload),
    .valid_address       (valid_address),
    .sram_result_address (sram_result_address),
    .sram_result_data_out(sram_result_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [RW-1:0] ref_y(input logic [XW-1:0] x, input logic [FW-1:0] w);
    logic [RW-1:0] y;
    logic [7:0]    xb;
    logic [7:0]    wb;
    logic [23:0]   lane;
    int            s;
    y = '0;
    for (int c = 0; c < 16; c++) begin
      s = 0;
      for (int k = 0; k < 16; k++) begin
        xb = x[k*8 +: 8];
        wb = w[(k*16 + c)*8 +: 8];
        s  = s + int'($signed(xb)) * int'($signed(wb));
      end
      lane = s[23:0];
`ifdef VEC_MUL_RELU_EN
      if (lane[23]) lane = '0;
`endif
      y[c*24 +: 24] = lane;
    end
    return y;
  endfunction

  function automatic logic [FW-1:0] rand_mat();
    logic [FW-1:0] m;
    for (int i = 0; i < FW/32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  function automatic logic [XW-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_mat(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed(low128) %h expected(low128) %h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic write_row(input logic [AW-1:0] a, input logic [XW-1:0] d);
    sram_address      = a;
    sram_data_in      = d;
    sram_write_enable = 1'b1;
    tick();
    sram_write_enable = 1'b0;
  endtask

  task automatic push(input logic [FW-1:0] m);
    fifo_data_in      = m;
    fifo_write_enable = 1'b1;
    tick();
    fifo_write_enable = 1'b0;
  endtask

  task automatic pop();
    fifo_read_enable = 1'b1;
    tick();
    fifo_read_enable = 1'b0;
  endtask

  task automatic reload();
    weight_reload = 1'b1;
    tick();
    weight_reload = 1'b0;
  endtask

  // Leaves the caller just after the request edge.
  task automatic run_one(input logic [AW-1:0] a);
    start = 1'b1;
    tick();
    sram_address  = a;
    valid_address = 1'b1;
    tick();
    valid_address = 1'b0;
  endtask

  // Counts edges until end_ is seen, bounded.
  task automatic wait_end(output int cyc);
    cyc = 0;
    while (end_ !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [XW-1:0] rows [16];
  logic [FW-1:0] mats [5];
  logic [FW-1:0] ident;
  logic [FW-1:0] w_a;
  logic [FW-1:0] w_q;
  logic [FW-1:0] w_80;
  logic [FW-1:0] w_81;
  logic [XW-1:0] v500;
  logic [RW-1:0] ident_res;
  logic [RW-1:0] saved3;
  int            cyc;
  int            pulses;

  initial begin
    rstn = 1'b1; start = 1'b0; sram_write_enable = 1'b0; sram_address = '0;
    sram_data_in = '0; fifo_write_enable = 1'b0; fifo_read_enable = 1'b0;
    fifo_data_in = '0; weight_reload = 1'b0; valid_address = 1'b0;
    sram_result_address = '0;
    tick();
    tick();
    rstn = 1'b0;

    check("rst_end", RW'(end_), RW'(1'b0));
    check_mat("rst_fifo_out", fifo_data_out, '0);

    // Input SRAM load and read back
    for (int i = 0; i < 16; i++) begin
      rows[i] = rand_row();
      write_row(AW'(i), rows[i]);
    end
    for (int i = 0; i < 16; i++) begin
      sram_address = AW'(i);
      #1;
      check($sformatf("row_rd%0d", i), RW'(sram_data_out), RW'(rows[i]));
    end
    v500 = rand_row();
    write_row(AW'(500), v500);
    sram_address = AW'(500);
    #1;
    check("row_rd500", RW'(sram_data_out), RW'(v500));
    // A write with valid_address high is blocked.
    sram_data_in      = ~v500;
    sram_write_enable = 1'b1;
    valid_address     = 1'b1;
    tick();
    sram_write_enable = 1'b0;
    valid_address     = 1'b0;
    check("row_wr_blocked", RW'(sram_data_out), RW'(v500));

    // FIFO: four entries fit, fifth push dropped; entry 3 is the identity.
    ident = '0;
    for (int r = 0; r < 16; r++) ident[(r*16 + r)*8 +: 8] = 8'd1;
    for (int i = 0; i < 5; i++) mats[i] = rand_mat();
    mats[3] = ident;
    for (int i = 0; i < 5; i++) push(mats[i]);
    for (int i = 0; i < 4; i++) begin
      pop();
      check_mat($sformatf("fifo_pop%0d", i), fifo_data_out, mats[i]);
    end
    pop();
    check_mat("fifo_pop_empty", fifo_data_out, mats[3]);

    // Identity weights, row 0 = 1..16, exact 3-edge latency.
    reload();
    for (int k = 0; k < 16; k++) rows[0][k*8 +: 8] = 8'(k + 1);
    write_row(AW'(0), rows[0]);
    sram_result_address = '0;
    run_one(AW'(0));
    tick();
    tick();
    tick();
    check("ident_lat3", sram_result_data_out, ref_y(rows[0], ident));
    ident_res = sram_result_data_out;
    tick();
    check("ident_end", RW'(end_), RW'(1'b1));
    start = 1'b0;
    tick();
    tick();

    // Random back-to-back run with a reload attempt during RUN.
    w_a = rand_mat();
    w_q = rand_mat();
    push(w_a);
    pop();
    reload();
    push(w_q);
    pop();
    for (int i = 0; i < 16; i++) begin
      rows[i] = rand_row();
      write_row(AW'(i), rows[i]);
    end
    sram_result_address = '0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      sram_address  = AW'(i);
      valid_address = 1'b1;
      weight_reload = 1'b1;
      tick();
      if (i == 2) check("rand_lat_before", sram_result_data_out, ident_res);
      if (i == 3) check("rand_lat_at3", sram_result_data_out, ref_y(rows[0], w_a));
    end
    valid_address = 1'b0;
    weight_reload = 1'b0;
    wait_end(cyc);
    check("rand_end_lat", RW'(cyc), RW'(4));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (end_ === 1'b1) pulses++;
    end
    check("rand_no_retrigger", RW'(pulses), RW'(0));
    for (int i = 0; i < 16; i++) begin
      sram_result_address = AW'(i);
      #1;
      check($sformatf("rand_y%0d", i), sram_result_data_out, ref_y(rows[i], w_a));
    end
    saved3 = ref_y(rows[3], w_a);
    start = 1'b0;
    tick();

    // Extreme operands.
    for (int k = 0; k < 16; k++) begin
      rows[0][k*8 +: 8] = 8'h80;
      rows[1][k*8 +: 8] = 8'h7F;
    end
    write_row(AW'(0), rows[0]);
    write_row(AW'(1), rows[1]);
    for (int i = 0; i < 256; i++) begin
      w_80[i*8 +: 8] = 8'h80;
      w_81[i*8 +: 8] = 8'h81;
    end
    push(w_80);
    pop();
    reload();
    run_one(AW'(0));
    wait_end(cyc);
    start = 1'b0;
    tick();
    tick();
    sram_result_address = AW'(0);
    #1;
    check("ext_80x80", sram_result_data_out, {16{24'h040000}});
    push(w_81);
    pop();
    reload();
    run_one(AW'(1));
    wait_end(cyc);
    start = 1'b0;
    tick();
    tick();
    sram_result_address = AW'(1);
    #1;
    check("ext_7Fx81", sram_result_data_out, ref_y(rows[1], w_81));

    // Reset during DRAIN: pending write lost, no end_ pulse.
    run_one(AW'(3));
    tick();
    rstn = 1'b1;
    tick();
    rstn  = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (end_ === 1'b1) pulses++;
    end
    check("rst_drain_no_end", RW'(pulses), RW'(0));
    sram_result_address = AW'(3);
    #1;
    check("rst_drain_lost", sram_result_data_out, saved3);

    // The FSM is back in IDLE and the weight register was cleared.
    run_one(AW'(2));
    wait_end(cyc);
    check("post_rst_end_lat", RW'(cyc), RW'(4));
    start = 1'b0;
    tick();
    tick();
    sram_result_address = AW'(2);
    #1;
    check("post_rst_zero_w", sram_result_data_out, ref_y(rows[2], '0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
